// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared widths and FSM state type for the matrix multiply datapath
package matmul_pkg;

  localparam int MM_ADDR_WIDTH = 12;
  localparam int MM_DATA_WIDTH = 32;
  localparam int MM_DIM_WIDTH  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/result_fifo.sv
// rtl/result_fifo.sv - synchronous FIFO buffering results ahead of the memory write port
module result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] storage_q [DEPTH];
  logic             do_push, do_pop;

  // Extra wrap bit distinguishes full from empty when the indices match.
  assign count = wr_ptr_q - rd_ptr_q;
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout  = storage_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      storage_q[wr_ptr_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/matrix_result_writer.sv
// rtl/matrix_result_writer.sv - writes the row-major C stream to memory at c_base + row*ldc + col
module matrix_result_writer
  import matmul_pkg::*;
#(
  parameter int ADDR_WIDTH = MM_ADDR_WIDTH,
  parameter int DATA_WIDTH = MM_DATA_WIDTH,
  parameter int DIM_WIDTH  = MM_DIM_WIDTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] c_base,
  input  logic [DIM_WIDTH-1:0]  N,
  input  logic [DIM_WIDTH-1:0]  P,
  input  logic [DIM_WIDTH-1:0]  ldc,
  input  logic                  res_valid,
  input  logic [DATA_WIDTH-1:0] res_data,
  output logic                  res_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  err_drop
);

  localparam int CNT_W = 2 * DIM_WIDTH;
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] row_addr_q, row_addr_d;
  logic [DIM_WIDTH-1:0]  col_q, col_d;
  logic [DIM_WIDTH-1:0]  p_q, p_d;
  logic [DIM_WIDTH-1:0]  ldc_q, ldc_d;
  logic [CNT_W-1:0]      total_q, total_d;
  logic [CNT_W-1:0]      accepted_q, accepted_d;
  logic [CNT_W-1:0]      written_q, written_d;
  logic                  err_drop_q, err_drop_d;

  logic                  push, pop;
  logic                  fifo_full, fifo_empty;
  logic [PTR_W:0]        fifo_count;
  logic [DATA_WIDTH-1:0] fifo_head;

  // Ready never looks at res_valid so the producer can't form a combinational loop.
  assign res_ready = (state_q == ST_RUN) && !fifo_full && (accepted_q < total_q);
  assign push      = res_valid && res_ready && (fifo_count < PTR_W'(FIFO_DEPTH - 1) + 1'b1);
  assign mem_we    = !fifo_empty;
  assign pop       = mem_we && mem_ready;
  assign mem_addr  = mem_we ? (row_addr_q + ADDR_WIDTH'(col_q)) : '0;
  assign mem_wdata = mem_we ? fifo_head : '0;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign err_drop  = err_drop_q;

  result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (res_data),
    .pop   (pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d    = state_q;
    row_addr_d = row_addr_q;
    col_d      = col_q;
    p_d        = p_q;
    ldc_d      = ldc_q;
    total_d    = total_q;
    accepted_d = accepted_q;
    written_d  = written_q;
    err_drop_d = err_drop_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          row_addr_d = c_base;
          col_d      = '0;
          p_d        = P;
          ldc_d      = ldc;
          total_d    = CNT_W'(N) * CNT_W'(P);
          accepted_d = '0;
          written_d  = '0;
          err_drop_d = 1'b0;
          state_d    = (total_d == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (push) begin
          accepted_d = accepted_q + 1'b1;
        end
        if (pop) begin
          written_d = written_q + 1'b1;
          if (col_q == p_q - 1'b1) begin
            col_d      = '0;
            row_addr_d = row_addr_q + ADDR_WIDTH'(ldc_q);
          end else begin
            col_d = col_q + 1'b1;
          end
          if (written_d == total_q) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Outside RUN res_ready is low, so any res_valid there is a drop as well.
    if (res_valid && !res_ready) begin
      err_drop_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      row_addr_q <= '0;
      col_q      <= '0;
      p_q        <= '0;
      ldc_q      <= '0;
      total_q    <= '0;
      accepted_q <= '0;
      written_q  <= '0;
      err_drop_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_addr_q <= row_addr_d;
      col_q      <= col_d;
      p_q        <= p_d;
      ldc_q      <= ldc_d;
      total_q    <= total_d;
      accepted_q <= accepted_d;
      written_q  <= written_d;
      err_drop_q <= err_drop_d;
    end
  end

endmodule

// File: tb/tb_matrix_result_writer.sv
// tb/tb_matrix_result_writer.sv - randomized self-checking bench for matrix_result_writer
module tb_matrix_result_writer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [11:0] c_base;
  logic [3:0]  n_dim, p_dim, ldc;
  logic        res_valid;
  logic [31:0] res_data;
  logic        res_ready;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic        busy, done, err_drop;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  matrix_result_writer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .c_base    (c_base),
    .N         (n_dim),
    .P         (p_dim),
    .ldc       (ldc),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_ready (res_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .busy      (busy),
    .done      (done),
    .err_drop  (err_drop)
  );

  // Cycle 0 carries the start pulse; the expected write list is built from row/col arithmetic.
  task automatic run_job(input logic [11:0] base, input int n, input int p, input int ld,
                         input int rdy_pct, input int vld_pct, input int stall_len,
                         input bit do_drop, input bit seq_data,
                         output int first_acc, output int first_wr, output int last_wr,
                         output int done_cyc, output int acc_at_stall, output int wr_at_stall,
                         output logic rdy_at_stall);
    logic [11:0] exp_addr[$];
    logic [31:0] exp_data[$];
    int total, sent, widx, cyc;
    bit prev_stall;
    logic [11:0] prev_addr;
    logic [31:0] prev_data;
    total = n * p;
    for (int r = 0; r < n; r++) begin
      for (int c = 0; c < p; c++) begin
        exp_addr.push_back(12'((int'(base) + r * ld + c) % 4096));
        exp_data.push_back(seq_data ? 32'(exp_data.size() + 1) : $urandom);
      end
    end
    first_acc = -1; first_wr = -1; last_wr = -1; done_cyc = -1;
    acc_at_stall = -1; wr_at_stall = -1; rdy_at_stall = 1'bx;
    sent = 0; widx = 0; cyc = 0; prev_stall = 0; prev_addr = '0; prev_data = '0;
    while (cyc < 3000) begin
      @(negedge clk);
      start = (cyc == 0);
      if (cyc == 0) begin
        c_base = base; n_dim = 4'(n); p_dim = 4'(p); ldc = 4'(ld);
      end
      mem_ready = (cyc < stall_len) ? 1'b0 : ($urandom_range(99) < rdy_pct);
      res_valid = 1'b0;
      if (cyc > 0 && sent < total && res_ready && $urandom_range(99) < vld_pct) begin
        res_valid = 1'b1; res_data = exp_data[sent]; sent++;
      end else if (do_drop && cyc == stall_len - 1 && !res_ready) begin
        res_valid = 1'b1; res_data = 32'hdead_beef;
      end
      #4;
      if (res_valid && res_ready && first_acc < 0) first_acc = cyc;
      if (cyc == stall_len - 1) begin
        acc_at_stall = sent; wr_at_stall = widx; rdy_at_stall = res_ready;
      end
      if (mem_we && mem_ready) begin
        if (first_wr < 0) first_wr = cyc;
        last_wr = cyc;
        vectors++;
        if (widx >= total) begin
          miscompares++;
          $display("FAIL extra_write: got addr=%h data=%h, expected no write", mem_addr, mem_wdata);
        end else if (mem_addr !== exp_addr[widx] || mem_wdata !== exp_data[widx]) begin
          miscompares++;
          $display("FAIL write[%0d]: got (%h,%h), expected (%h,%h)", widx, mem_addr, mem_wdata,
                   exp_addr[widx], exp_data[widx]);
        end
        widx++;
      end
      if (prev_stall) begin
        vectors++;
        if (mem_we !== 1'b1 || mem_addr !== prev_addr || mem_wdata !== prev_data) begin
          miscompares++;
          $display("FAIL stall_hold: got (%b,%h,%h), expected (1,%h,%h)", mem_we, mem_addr,
                   mem_wdata, prev_addr, prev_data);
        end
      end
      prev_stall = mem_we && !mem_ready;
      prev_addr = mem_addr;
      prev_data = mem_wdata;
      if (done_cyc >= 0) begin
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
          miscompares++;
          $display("FAIL after_done: got busy=%b done=%b, expected 0 0", busy, done);
        end
        break;
      end
      if (done === 1'b1) begin
        done_cyc = cyc;
        vectors++;
        if (busy !== 1'b1) begin
          miscompares++;
          $display("FAIL busy_in_done: got %b, expected 1", busy);
        end
      end
      cyc++;
    end
    vectors++;
    if (done_cyc < 0) begin
      miscompares++;
      $display("FAIL job_timeout: got no done in %0d cycles, expected done", cyc);
    end
    vectors++;
    if (widx !== total) begin
      miscompares++;
      $display("FAIL write_count: got %0d, expected %0d", widx, total);
    end
    vectors++;
    if (err_drop !== do_drop) begin
      miscompares++;
      $display("FAIL err_drop_end: got %b, expected %b", err_drop, do_drop);
    end
    start = 1'b0; res_valid = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; res_valid = 1'b0; mem_ready = 1'b0;
    c_base = '0; n_dim = '0; p_dim = '0; ldc = '0; res_data = '0;
    repeat (3) @(negedge clk);
    #4;
    vectors++;
    if ({res_ready, mem_we, mem_addr, mem_wdata, busy, done, err_drop} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got rr=%b we=%b a=%h d=%h busy=%b done=%b err=%b, expected all 0",
               res_ready, mem_we, mem_addr, mem_wdata, busy, done, err_drop);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int fa, fw, lw, dc, as, ws; logic rs;
    run_job(12'h100, 2, 2, 2, 100, 100, 0, 1'b0, 1'b1, fa, fw, lw, dc, as, ws, rs);
    vectors++;
    if (fw !== fa + 1) begin
      miscompares++;
      $display("FAIL basic_latency: got first write cycle %0d, expected %0d", fw, fa + 1);
    end
    vectors++;
    if (lw - fw !== 3) begin
      miscompares++;
      $display("FAIL basic_throughput: got span %0d, expected 3", lw - fw);
    end
    vectors++;
    if (dc !== lw + 1) begin
      miscompares++;
      $display("FAIL basic_done: got done cycle %0d, expected %0d", dc, lw + 1);
    end
  endtask

  task automatic test_stride();
    int fa, fw, lw, dc, as, ws; logic rs;
    run_job(12'h010, 2, 3, 5, 100, 100, 0, 1'b0, 1'b0, fa, fw, lw, dc, as, ws, rs);
    vectors++;
    if (dc !== lw + 1) begin
      miscompares++;
      $display("FAIL stride_done: got done cycle %0d, expected %0d", dc, lw + 1);
    end
  endtask

  task automatic test_backpressure_drop();
    int fa, fw, lw, dc, as, ws; logic rs;
    run_job(12'($urandom), 4, 4, 4, 100, 100, 10, 1'b1, 1'b0, fa, fw, lw, dc, as, ws, rs);
    vectors++;
    if (as !== 4 || ws !== 0 || rs !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_fill: got accepted=%0d writes=%0d ready=%b, expected 4 0 0", as, ws, rs);
    end
    repeat (3) @(negedge clk);
    #4;
    vectors++;
    if (err_drop !== 1'b1) begin
      miscompares++;
      $display("FAIL err_drop_sticky: got %b, expected 1", err_drop);
    end
    run_job(12'h300, 1, 3, 3, 100, 100, 0, 1'b0, 1'b0, fa, fw, lw, dc, as, ws, rs);
  endtask

  task automatic test_wrap();
    int fa, fw, lw, dc, as, ws; logic rs;
    run_job(12'hffe, 1, 4, 4, 70, 80, 0, 1'b0, 1'b0, fa, fw, lw, dc, as, ws, rs);
  endtask

  task automatic test_zero();
    int fa, fw, lw, dc, as, ws; logic rs;
    run_job(12'h123, 0, 5, 5, 100, 100, 0, 1'b0, 1'b0, fa, fw, lw, dc, as, ws, rs);
    vectors++;
    if (dc !== 1 || fw !== -1) begin
      miscompares++;
      $display("FAIL zero_rows: got done cycle %0d first write %0d, expected 1 -1", dc, fw);
    end
    run_job(12'h456, 3, 0, 2, 100, 100, 0, 1'b0, 1'b0, fa, fw, lw, dc, as, ws, rs);
    vectors++;
    if (dc !== 1 || fw !== -1) begin
      miscompares++;
      $display("FAIL zero_cols: got done cycle %0d first write %0d, expected 1 -1", dc, fw);
    end
  endtask

  task automatic test_idle_drop();
    int fa, fw, lw, dc, as, ws; logic rs;
    @(negedge clk);
    res_valid = 1'b1; res_data = 32'h1234_5678;
    @(negedge clk);
    res_valid = 1'b0;
    #4;
    vectors++;
    if (err_drop !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_drop: got err=%b busy=%b, expected 1 0", err_drop, busy);
    end
    run_job(12'h040, 2, 2, 3, 100, 100, 0, 1'b0, 1'b0, fa, fw, lw, dc, as, ws, rs);
  endtask

  task automatic test_reset_midjob();
    int fa, fw, lw, dc, as, ws; logic rs;
    @(negedge clk);
    start = 1'b1; c_base = 12'h200; n_dim = 4'd4; p_dim = 4'd4; ldc = 4'd4; mem_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      res_valid = res_ready; res_data = $urandom;
      @(negedge clk);
    end
    res_valid = 1'b0;
    vectors++;
    if (busy !== 1'b1 || mem_we !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_abort: got busy=%b we=%b, expected 1 1", busy, mem_we);
    end
    mem_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({res_ready, mem_we, mem_addr, mem_wdata, busy, done, err_drop} !== '0) begin
      miscompares++;
      $display("FAIL abort_outputs: got rr=%b we=%b a=%h d=%h busy=%b done=%b err=%b, expected all 0",
               res_ready, mem_we, mem_addr, mem_wdata, busy, done, err_drop);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #4;
      vectors++;
      if (mem_we !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL abort_hold: got we=%b busy=%b, expected 0 0", mem_we, busy);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b0;
    run_job(12'h500, 2, 2, 2, 100, 100, 0, 1'b0, 1'b1, fa, fw, lw, dc, as, ws, rs);
    vectors++;
    if (dc !== lw + 1) begin
      miscompares++;
      $display("FAIL post_abort_done: got done cycle %0d, expected %0d", dc, lw + 1);
    end
  endtask

  task automatic test_random();
    int fa, fw, lw, dc, as, ws; logic rs;
    int n, p, ld;
    for (int j = 0; j < 12; j++) begin
      n = $urandom_range(5);
      p = $urandom_range(5);
      ld = p + $urandom_range(3);
      run_job(12'($urandom), n, p, ld, 30 + $urandom_range(70), 30 + $urandom_range(70), 0,
              1'b0, 1'b0, fa, fw, lw, dc, as, ws, rs);
      vectors++;
      if (n * p > 0 && dc !== lw + 1) begin
        miscompares++;
        $display("FAIL random_done[%0d]: got done cycle %0d, expected %0d", j, dc, lw + 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stride();
    test_backpressure_drop();
    test_wrap();
    test_zero();
    test_idle_drop();
    test_reset_midjob();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/matrix_result_writer.md
# matrix_result_writer

Downstream stage of `matrix_multiplication`. It consumes the row-major stream of C elements (`result_out`/`valid_out`) and writes each element to data memory at `c_base + row*ldc + col`. A small FIFO absorbs memory backpressure. The block reports completion and detects results dropped because the producer ignored `res_ready`.

## Interface
- `ADDR_WIDTH`, 12: memory word-address width.
- `DATA_WIDTH`, 32: element width.
- `DIM_WIDTH`, 4: width of N, P and ldc.
- `FIFO_DEPTH`, 4: result buffer entries; must be a power of two and at least 2.

- `clk`  in  1: the single clock; all logic is on its rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: one-cycle pulse that latches the job parameters; ignored while `busy`.
- `c_base`  in  ADDR_WIDTH: base address of C (the matrix_c_addr value).
- `N`  in  DIM_WIDTH: number of rows of C.
- `P`  in  DIM_WIDTH: number of columns of C.
- `ldc`  in  DIM_WIDTH: row stride in words; requires ldc ≥ P, and ldc < P is unsupported.
- `res_valid`  in  1: result element valid (from `valid_out`).
- `res_data`  in  DATA_WIDTH: result element (from `result_out`).
- `res_ready`  out  1: the block can accept an element this cycle.
- `mem_we`  out  1: write request.
- `mem_addr`  out  ADDR_WIDTH: write address.
- `mem_wdata`  out  DATA_WIDTH: write data.
- `mem_ready`  in  1: memory accepts the write this cycle.
- `busy`  out  1: a job is in progress.
- `done`  out  1: one-cycle completion pulse.
- `err_drop`  out  1: sticky flag; an element was dropped.

## Operation
- FSM states: IDLE, RUN, DONE.
- Reset values: state IDLE; FIFO empty; all counters zero; every output 0.
- IDLE, on `start`:
  - latch `c_base`, `N`, `P` and `ldc`;
  - clear `err_drop`;
  - total = N*P, computed at full 2*DIM_WIDTH width.
  - If total = 0, go to DONE with no writes. Otherwise go to RUN.
- RUN, input side:
  - An element is accepted on `res_valid && res_ready`.
  - `res_ready` = (state == RUN) && (fifo_count < FIFO_DEPTH) && (accepted < total).
  - `res_ready` depends only on state and counters, never on `res_valid`.
- RUN, output side:
  - `mem_we` = FIFO non-empty.
  - `mem_wdata` = FIFO head.
  - `mem_addr` = row_addr + col.
  - A write completes on `mem_we && mem_ready`; the FIFO then pops and the col/row counters advance.
  - After col = P-1: col returns to 0, row increments, row_addr += ldc.
  - Address arithmetic wraps modulo 2^ADDR_WIDTH without error.
- Push and pop in the same cycle: both occur and the count is unchanged. A full FIFO does not accept, even while popping.
- `err_drop` sets on `res_valid && !res_ready` in RUN. It also sets on `res_valid` in IDLE or DONE. Dropped data is discarded and the job is unaffected.
- RUN → DONE in the cycle after the write handshake for element total-1.
- DONE: `done` = 1 for one cycle, then → IDLE.
- `busy` = (state != IDLE).
- `start` during RUN or DONE is ignored.
- `rst_n` low mid-job: the job is aborted immediately, the FIFO is flushed, and no further writes occur.

## Timing
- Element accepted at edge t: earliest `mem_we` is in cycle t+1 (registered FIFO, no bypass).
- Sustained throughput: 1 element per cycle with `mem_ready` held high.
- `mem_we`, `mem_addr` and `mem_wdata` remain stable while `mem_ready` = 0.
- Last write handshake at edge t: `done` is high in cycle t+1 and `busy` falls in cycle t+2.
- Zero-size job started at edge t: `done` is high in cycle t+1.

## Structure
- Shared package `matmul_pkg`:
  - the FSM state enum;
  - ADDR/DATA/DIM width constants, also used by `matrix_multiplication`.
- Sub-module `result_fifo`:
  - synchronous FIFO with push, pop, full, empty and count;
  - pointers of log2(FIFO_DEPTH) bits plus a wrap bit;
  - async active-low reset.
- The top level holds the FSM, the accepted/written counters and the row/col address generator.

## Test plan
- N=P=ldc=2, c_base=0x100, stream 1,2,3,4 back-to-back with `mem_ready`=1 → writes (0x100,1), (0x101,2), (0x102,3), (0x103,4); `done` one cycle after the last write; `err_drop`=0.
- N=2, P=3, ldc=5, c_base=0x010 → write addresses 0x010, 0x011, 0x012, 0x015, 0x016, 0x017.
- `mem_ready`=0 for 10 cycles during a 4×4 job → `res_ready` drops after 4 accepts; `mem_*` held stable; all 16 writes occur in order with correct data.
- Producer asserts `res_valid` while `res_ready`=0 → `err_drop`=1 and stays 1 until the next `start`.
- c_base=0xFFE, N=1, P=4, ldc=4 → addresses 0xFFE, 0xFFF, 0x000, 0x001.
- Two boundary cases:
  - N=0 → `done` one cycle after `start`, with no `mem_we`;
  - `rst_n` pulsed low mid-job → all outputs 0 at once, and the next job runs cleanly.
